// File: rtl/fb_pkg.sv
// Shared types, default geometry and address packing for the ping-pong pixel frame store.
package fb_pkg;

  localparam int DEF_ROW_W = 6;
  localparam int DEF_COL_W = 7;
  localparam int DEF_PIX_W = 12;

  typedef enum logic [1:0] {
    FILL,
    WAIT_SWAP,
    CLEAR
  } fb_state_t;

  // Bank address is {col,row}, column in the upper bits.
  function automatic logic [31:0] pack_addr(input logic [31:0] col,
                                            input logic [31:0] row,
                                            input int          row_w);
    return (col << row_w) | row;
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// One pixel bank: simple dual-port RAM, one write port and a registered read port (latency 1).
// The read register only updates on re, so rdata holds between reads; contents are not reset.
module fb_bank_ram #(
  parameter int AW = 13,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Double-buffered pixel store: tracer fills the back bank, banks swap only in vblank; read latency 1.
// wr_ready is low from the accepted last pixel until the swap and through any clear pass.
module pixel_frame_buffer
  import fb_pkg::*;
#(
  parameter int               ROW_W       = DEF_ROW_W,
  parameter int               COL_W       = DEF_COL_W,
  parameter int               PIX_W       = DEF_PIX_W,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_last,
  input  logic             clear_en,
  input  logic             rd_en,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             vblank,
  output logic             swap_done,
  output logic             front_sel,
  output logic [7:0]       frame_cnt
);

  localparam int AW = COL_W + ROW_W;

  fb_state_t     state;
  logic [AW-1:0] clr_addr;
  logic          rd_sel;
  logic          fill_we;
  logic          clr_we;
  logic          bank_we;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic [PIX_W-1:0] w_dat;
  logic [PIX_W-1:0] q0;
  logic [PIX_W-1:0] q1;

  assign fill_we = (state == FILL) && wr_valid && wr_ready;
  assign clr_we  = (state == CLEAR);
  assign bank_we = fill_we || clr_we;
  assign w_addr  = clr_we ? clr_addr : AW'(pack_addr(32'(wr_col), 32'(wr_row), ROW_W));
  assign w_dat   = clr_we ? CLEAR_COLOR : wr_data;
  assign r_addr  = AW'(pack_addr(32'(rd_col), 32'(rd_row), ROW_W));

  // The back bank is always the one not on display.
  fb_bank_ram #(.AW(AW), .DW(PIX_W)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we && front_sel),
    .waddr (w_addr),
    .wdata (w_dat),
    .re    (rd_en),
    .raddr (r_addr),
    .rdata (q0)
  );

  fb_bank_ram #(.AW(AW), .DW(PIX_W)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we && !front_sel),
    .waddr (w_addr),
    .wdata (w_dat),
    .re    (rd_en),
    .raddr (r_addr),
    .rdata (q1)
  );

  // rd_sel remembers which bank was front when the read was issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_sel   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_sel <= front_sel;
    end
  end

  assign rd_data = rd_sel ? q1 : q0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      wr_ready  <= 1'b1;
      swap_done <= 1'b0;
      front_sel <= 1'b0;
      frame_cnt <= 8'd0;
      clr_addr  <= '0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        FILL: begin
          if (wr_valid && wr_ready && wr_last) begin
            state    <= WAIT_SWAP;
            wr_ready <= 1'b0;
          end
        end
        WAIT_SWAP: begin
          if (vblank) begin
            front_sel <= ~front_sel;
            swap_done <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            if (clear_en) begin
              state <= CLEAR;
            end else begin
              state    <= FILL;
              wr_ready <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (&clr_addr) begin
            state    <= FILL;
            wr_ready <= 1'b1;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        default: begin
          state    <= FILL;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/pixel_frame_buffer.md
# pixel_frame_buffer

Parametrised double-buffered (ping-pong) pixel frame store between the ray tracer (write side) and the VGA scan-out (read side), all on one clock. The tracer fills the back bank through a valid/ready port and marks the last pixel of a frame. The block then swaps banks only at vertical blanking, so the display never shows a partially traced frame. After each swap it can optionally clear the new back bank to a fixed colour.

## Interface
Parameters:
- ROW_W, 6, row address width (64 blocks of 8×8 pixels)
- COL_W, 7, column address width (128 blocks of 8×8 pixels)
- PIX_W, 12, pixel width (4:4:4 RGB)
- CLEAR_COLOR, 12'h000, value written by a clear pass (width PIX_W)

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-low reset
- wr_valid  in  1  tracer presents a pixel
- wr_ready  out  1  block accepts the pixel this cycle
- wr_col  in  COL_W  write column
- wr_row  in  ROW_W  write row
- wr_data  in  PIX_W  pixel value
- wr_last  in  1  marks the accepted pixel as the frame's final pixel
- clear_en  in  1  sampled at each swap; 1 means clear the new back bank
- rd_en  in  1  VGA read request
- rd_col  in  COL_W  read column
- rd_row  in  ROW_W  read row
- rd_data  out  PIX_W  front-bank pixel
- rd_valid  out  1  rd_data is valid
- vblank  in  1  level-high during vertical blanking
- swap_done  out  1  one-cycle pulse on the cycle the swap takes effect
- front_sel  out  1  index of the bank currently displayed
- frame_cnt  out  8  count of completed swaps; wraps from 255 to 0

## Operation
- Each bank has DEPTH = 2^(COL_W+ROW_W) entries. Address = {col,row}, column in the MSBs. Every address is in range.
- The back bank is bank !front_sel. Writes go only to the back bank; reads come only from the front bank.
- FSM states: FILL, WAIT_SWAP, CLEAR.
  - FILL: wr_ready=1. A write occurs when wr_valid&&wr_ready. If the accepted pixel has wr_last=1, the next state is WAIT_SWAP.
  - WAIT_SWAP: wr_ready=0. In the first cycle with vblank=1:
    - toggle front_sel;
    - pulse swap_done;
    - frame_cnt++;
    - latch clear_en.
    The next state is CLEAR if the latched clear_en=1, otherwise FILL.
  - CLEAR: wr_ready=0. A counter clr_addr runs 0..DEPTH-1 and writes CLEAR_COLOR to the new back bank, one address per cycle. After address DEPTH-1 is written, the next state is FILL. The counter returns to 0.
- The read path runs independently of the FSM in every state.
- Write-side data is not checked for duplicate or missing addresses. Unwritten back-bank addresses keep their previous contents.

## Timing
- Reset values: state=FILL, wr_ready=1, rd_data=0, rd_valid=0, swap_done=0, front_sel=0, frame_cnt=0, clr_addr=0. Memory contents are not reset.
- Read latency is 1: rd_en at cycle t gives rd_data and rd_valid=1 at t+1. With rd_en=0, rd_valid=0 and rd_data holds its value.
- A read issued in the swap cycle uses the old front bank. Reads from the next cycle on use the new front bank.
- If wr_last is accepted at cycle t, WAIT_SWAP begins at t+1. The earliest swap is at t+1, when vblank=1 at t+1; a swap never happens in the same cycle as the last write.
- A long vblank causes exactly one swap. A further swap needs a new full frame (FILL → wr_last).
- A CLEAR pass takes exactly DEPTH cycles, with wr_ready low throughout. FILL resumes on cycle DEPTH+1 after the swap.
- wr_valid while wr_ready=0 is ignored; the tracer must hold its data.
- Reset asserted mid-CLEAR or mid-WAIT_SWAP goes straight to the reset state with no swap. Partially cleared contents remain.
- frame_cnt wraps from 255 to 0 on a swap with no other effect.

## Structure
- Shared package `fb_pkg`:
  - FSM state enum (FILL, WAIT_SWAP, CLEAR);
  - default ROW_W, COL_W, PIX_W constants;
  - the {col,row} address-pack function.
- One sub-module, `fb_bank_ram`: simple dual-port RAM with one write port and one registered read port, parametrised by address and data width, instantiated twice.
- Top level holds the FSM, clear counter, bank steering (wr_en gated by bank index, rd_data muxed by a registered copy of front_sel) and the frame counter.

## Test plan
- Reset, then write 0xABC to (col 5, row 3) and 0x123 to (0,0) with wr_last on the second write. Hold vblank=1. Expect swap_done pulse; front_sel=1; frame_cnt=1; reading (5,3) gives 0xABC one cycle after rd_en.
- Hold vblank=0 for 100 cycles after wr_last. Expect wr_ready=0, no swap, and reads returning old front data. Raise vblank: swap occurs that cycle and ready returns the next cycle.
- clear_en=1 at swap with CLEAR_COLOR=0x000. Expect wr_ready low for exactly 8192 cycles, then every address of the new back bank reads 0x000 after the following swap.
- Issue rd_en in the swap cycle and the cycle after. The first read returns the old bank's data, the second the new bank's.
- Assert rst low mid-CLEAR at clr_addr=100. Expect every output at its reset value immediately, then state FILL after release.
- Perform 256 swaps. frame_cnt returns to 0 and front_sel equals 0.
